// File: rtl/pixel_packer.sv
// Packs 4-bit edge-magnitude pixels eight per 32-bit word (first pixel in the LSBs) and queues the words in a small FIFO.
// Optional feature: define PIXEL_PACKER_WORDCNT_EN to add the word_count output. n_rst is synchronous and active-high.
module pixel_packer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [3:0]  pixel_in,
  input  logic        pixel_valid,
  input  logic        frame_end,
  output logic [31:0] word_data,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        word_last,
  output logic        overflow,
`ifdef PIXEL_PACKER_WORDCNT_EN
  output logic [15:0] word_count,
`endif
  output logic        dbg_state_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   OCC_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   OCC_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic {EMPTY = 1'b0, FILL = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [2:0]  count_q, count_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] merged;
  logic        push, push_last;
  logic [31:0] push_word;

  logic [31:0]   mem_q [FIFO_DEPTH];
  logic          last_mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   occ_q;
  logic          overflow_q;
  logic          full, pop, accept;

  assign dbg_state_o = (state_q == FILL);

  // The incoming pixel lands in nibble slot count_q of the accumulator.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    acc_d     = acc_q;
    push      = 1'b0;
    push_last = 1'b0;
    push_word = acc_q;
    merged    = acc_q | (32'(pixel_in) << {count_q, 2'b00});
    if (pixel_valid) begin
      if (count_q == 3'd7 || frame_end) begin
        push      = 1'b1;
        push_word = merged;
        push_last = frame_end;
        state_d   = EMPTY;
        count_d   = 3'd0;
        acc_d     = 32'h0;
      end else begin
        acc_d   = merged;
        count_d = count_q + 3'd1;
        state_d = FILL;
      end
    end else if (frame_end && state_q == FILL) begin
      push      = 1'b1;
      push_last = 1'b1;
      push_word = acc_q;
      state_d   = EMPTY;
      count_d   = 3'd0;
      acc_d     = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q <= EMPTY;
      count_q <= 3'd0;
      acc_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
    end
  end

  assign word_valid = (occ_q != '0);
  assign full       = (occ_q == OCC_FULL);
  assign pop        = word_valid && word_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign accept     = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (!n_rst && accept) begin
      mem_q[wr_ptr_q]      <= push_word;
      last_mem_q[wr_ptr_q] <= push_last;
    end
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (accept) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)    rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (accept && !pop)      occ_q <= occ_q + OCC_ONE;
      else if (!accept && pop) occ_q <= occ_q - OCC_ONE;
      if (push && full && !pop) overflow_q <= 1'b1;
    end
  end

  assign word_data = word_valid ? mem_q[rd_ptr_q] : 32'h0;
  assign word_last = word_valid ? last_mem_q[rd_ptr_q] : 1'b0;
  assign overflow  = overflow_q;

`ifdef PIXEL_PACKER_WORDCNT_EN
  logic [15:0] word_count_q;

  // The frame's closing word is counted and the count restarts, so the register reads 0 afterwards.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      word_count_q <= 16'h0;
    end else if (pop) begin
      word_count_q <= word_last ? 16'h0 : word_count_q + 16'h1;
    end
  end

  assign word_count = word_count_q;
`endif

endmodule

// File: doc/pixel_packer.md
PIXEL_PACKER -- requirements
Module: pixel_packer

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the number of 32-bit word entries in the output FIFO (power of 2, >= 2).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port n_rst, input, 1, the reset: one clock, reset synchronous and active-high (asserted 1 sampled on rising clk edge).
REQ-004 The block SHALL have port pixel_in, input, 4, the quantised edge-magnitude pixel from the magnitude stage.
REQ-005 The block SHALL have port pixel_valid, input, 1, meaning pixel_in is valid this cycle; there is no upstream backpressure.
REQ-006 The block SHALL have port frame_end, input, 1, a one-cycle pulse marking the end of a frame.
REQ-007 The block SHALL have port word_data, output, 32, the packed word at the FIFO head.
REQ-008 The block SHALL have port word_valid, output, 1, meaning the FIFO is non-empty.
REQ-009 The block SHALL have port word_ready, input, 1, the downstream accept signal.
REQ-010 The block SHALL have port word_last, output, 1, the last-word-of-frame tag of the head entry.
REQ-011 The block SHALL have port overflow, output, 1, a sticky flag meaning a word was dropped.

Function
REQ-012 Packing SHALL place pixel k (k = 0..7, in arrival order) at word bits [4k+3:4k], with the first pixel at the LSBs.
REQ-013 The packer FSM SHALL have states EMPTY (count = 0) and FILL (count 1..7), with a 3-bit count that increments on each pixel_valid.
REQ-014 The 8th pixel SHALL complete the word: push to FIFO in the same cycle, count returns to 0, state becomes EMPTY.
REQ-015 On frame_end in FILL, or in EMPTY with pixel_valid the same cycle, the block SHALL push the partial word with unused nibbles zero, tag it last = 1, and go to EMPTY.
REQ-016 When frame_end coincides with the 8th pixel, the block SHALL push exactly one word, tagged last = 1.
REQ-017 When frame_end arrives in EMPTY with no pixel, the block SHALL push no word and leave its state unchanged.
REQ-018 A pushed word SHALL appear on word_data/word_valid the cycle after the push edge if the FIFO was empty, giving a latency of 1 cycle from the 8th pixel sample.
REQ-019 The downstream pop SHALL occur when word_valid && word_ready; word_data and word_last SHALL be held stable while word_valid && !word_ready.
REQ-020 When the FIFO is full, a push without a same-cycle pop SHALL drop the word, set overflow, and leave FIFO contents unchanged.
REQ-021 When the FIFO is full, a push with a same-cycle pop SHALL be accepted, with occupancy staying at FIFO_DEPTH.
REQ-022 Push and pop on an empty FIFO SHALL NOT bypass: the word appears the next cycle.
REQ-023 The FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH, and occupancy SHALL be tracked with log2(FIFO_DEPTH)+1 bits.
REQ-024 overflow SHALL remain 1 until reset.

Reset
REQ-025 While n_rst = 1 at a clk edge, the block SHALL clear count, state (to EMPTY), FIFO pointers, occupancy and overflow.
REQ-026 After reset, word_valid SHALL be 0, word_last 0, overflow 0, and word_data 32'h0.
REQ-027 A reset mid-word or with the FIFO non-empty SHALL discard the partial word and all stored words, with no flush word emitted.
REQ-028 Inputs sampled in a reset cycle SHALL be ignored.

Configuration
REQ-029 With macro PIXEL_PACKER_WORDCNT_EN defined, the block SHALL add output word_count [15:0], counting words popped since reset and wrapping 16'hFFFF -> 0.
REQ-030 With PIXEL_PACKER_WORDCNT_EN defined, word_count SHALL clear on reset and on the pop of a word_last = 1 entry (that pop is counted before the clear, i.e. the register shows 0 afterwards).
REQ-031 Without PIXEL_PACKER_WORDCNT_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-032 Bench: pixels 0..7 (values 1..8) on consecutive cycles with word_ready=1 -> word_data=32'h87654321 valid one cycle after 8th pixel, word_last=0.
REQ-033 Bench: 3 pixels (A,B,C) then frame_end -> word_data=32'h00000CBA, word_last=1; frame_end alone afterwards -> no word.
REQ-034 Bench: 8th pixel and frame_end in the same cycle -> exactly one word, word_last=1.
REQ-035 Bench: word_ready=0, 5 full words with FIFO_DEPTH=4 -> 4 words held, overflow=1 stays set; releasing word_ready -> first 4 words in order.
REQ-036 Bench: FIFO full, push and pop in the same cycle -> no overflow, order preserved; pointers wrap across 10+ words.
REQ-037 Bench: reset asserted after 5 pixels with 2 stored words -> word_valid=0 next cycle; next 8 pixels form a clean word.
